// File: rtl/masked_subbytes_seq_pkg.sv
// Shared constants, FSM encoding and byte-select helper for the masked SubBytes sequencer.
// Pure declarations: no latency, no flow control.
package masked_subbytes_seq_pkg;

    localparam int NBYTES           = 16;
    localparam int PRNG_W           = 46;
    localparam int SBOX_LAT_DEFAULT = 2;
    localparam int IDX_W            = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Index comes from a counter only, so the mux select never depends on share data.
    function automatic logic [7:0] byte_sel(input logic [8*NBYTES-1:0] v, input logic [3:0] idx);
        return v[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sbox_tag_pipe.sv
// Valid-tag shift register tracking which S-box pipeline slots carry real bytes.
// Latency DEPTH cycles; no backpressure, shifts every cycle and clears on reset.
module sbox_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tag_in,
    output logic tag_out
);

    logic [DEPTH-1:0] pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/masked_subbytes_seq.sv
// Masked SubBytes sequencer: streams 16 byte-share pairs to an external S-box and reassembles its outputs.
// Latency 17+SBOX_LAT cycles accept-to-valid; rnd_valid low stalls issue, out_ready low holds the result.
module masked_subbytes_seq #(
    parameter int SBOX_LAT = masked_subbytes_seq_pkg::SBOX_LAT_DEFAULT,
    parameter int PRNG_W   = masked_subbytes_seq_pkg::PRNG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_sh0,
    input  logic [127:0]      in_sh1,
    input  logic              rnd_valid,
    output logic              rnd_ready,
    input  logic [PRNG_W-1:0] rnd,
    output logic [7:0]        sb_inp0,
    output logic [7:0]        sb_inp1,
    output logic [PRNG_W-1:0] sb_prng,
    input  logic [7:0]        sb_f0,
    input  logic [7:0]        sb_f1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_sh0,
    output logic [127:0]      out_sh1
);

    import masked_subbytes_seq_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(NBYTES);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] issue_idx, col_idx;
    logic [127:0]     sh0_q, sh1_q;
    logic             accept, rnd_fire, tag_out, capture;

    assign accept   = (state == ST_IDLE) && in_valid;
    assign rnd_fire = (state == ST_ISSUE) && rnd_valid;
    assign capture  = tag_out && ((state == ST_ISSUE) || (state == ST_DRAIN));

    // Bubbles push a 0 tag so the S-box output for that slot is never captured.
    sbox_tag_pipe #(
        .DEPTH (SBOX_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (rnd_fire),
        .tag_out (tag_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: if (rnd_fire && (issue_idx == LAST_IDX)) state_nxt = ST_DRAIN;
            // Leave DRAIN on the edge that stores the last byte so out_valid is not delayed a cycle.
            ST_DRAIN: if ((col_idx == FULL_IDX) || (capture && (col_idx == LAST_IDX))) state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        rnd_ready = rnd_fire;
        sb_inp0   = '0;
        sb_inp1   = '0;
        sb_prng   = '0;
        if (rnd_fire) begin
            sb_inp0 = byte_sel(sh0_q, issue_idx[3:0]);
            sb_inp1 = byte_sel(sh1_q, issue_idx[3:0]);
            sb_prng = rnd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_idx <= '0;
            col_idx   <= '0;
            sh0_q     <= '0;
            sh1_q     <= '0;
            out_sh0   <= '0;
            out_sh1   <= '0;
        end else begin
            if (accept) begin
                sh0_q     <= in_sh0;
                sh1_q     <= in_sh1;
                issue_idx <= '0;
                col_idx   <= '0;
            end
            if (rnd_fire) begin
                issue_idx <= issue_idx + 1'b1;
            end
            if (capture) begin
                out_sh0[{col_idx[3:0], 3'b000} +: 8] <= sb_f0;
                out_sh1[{col_idx[3:0], 3'b000} +: 8] <= sb_f1;
                col_idx <= col_idx + 1'b1;
            end
        end
    end

endmodule
